// File: rtl/univ_shift_engine.sv
// Universal shift register: load/clear plus logical/arithmetic shifts and rotates
// by a runtime distance, advancing up to STEP bits per RUN cycle behind a valid/ready handshake.
package univ_shift_pkg;
  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;
endpackage

// One-bit move of the whole register; chained STEP deep to form a k-bit shift.
module univ_shift_step
  import univ_shift_pkg::*;
#(
  parameter int DW = 8
) (
  input  op_e           op,
  input  logic          fill,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] y
);
  always_comb begin
    y = d;
    if (en) begin
      case (op)
        OP_SHL:  y = {d[DW-2:0], fill};
        OP_SHR:  y = {fill, d[DW-1:1]};
        OP_ROL:  y = {d[DW-2:0], d[DW-1]};
        OP_ROR:  y = {d[0], d[DW-1:1]};
        OP_ASR:  y = {d[DW-1], d[DW-1:1]};
        default: y = d;
      endcase
    end
  end
endmodule

module univ_shift_engine
  import univ_shift_pkg::*;
#(
  parameter  int DW   = 8,
  parameter  int STEP = 2,
  localparam int AW   = $clog2(DW) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_amt,
  input  logic          cmd_fill,
  input  logic [DW-1:0] data,
  input  logic          flush,
  output logic [DW-1:0] q,
  output logic          busy,
  output logic          done
);
  localparam logic [AW-1:0] DW_A   = AW'(DW);
  localparam logic [AW-1:0] STEP_A = AW'(STEP);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e               state, state_nxt;
  op_e                  op_r, cmd_op_e;
  logic                 fill_r;
  logic [AW-1:0]        rem, eff_amt, step_k;
  logic                 accept, is_shift, is_rot, imm, last_step;
  logic [STEP:0][DW-1:0] stage;

  // Decode the incoming command and its effective distance.
  always_comb begin
    cmd_op_e = op_e'(cmd_op);
    is_shift = (cmd_op_e == OP_SHL) || (cmd_op_e == OP_SHR) || (cmd_op_e == OP_ASR);
    is_rot   = (cmd_op_e == OP_ROL) || (cmd_op_e == OP_ROR);
    eff_amt  = '0;
    if (is_shift)    eff_amt = (cmd_amt > DW_A) ? DW_A : cmd_amt;
    else if (is_rot) eff_amt = cmd_amt % DW_A;
    imm       = (eff_amt == '0);
    accept    = cmd_valid && (state == S_IDLE);
    last_step = (rem <= STEP_A);
    step_k    = last_step ? rem : STEP_A;
  end

  // Stage i moves one bit only while more than i bits remain, so the chain shifts min(STEP,rem).
  assign stage[0] = q;
  for (genvar i = 0; i < STEP; i++) begin : g_step
    univ_shift_step #(.DW(DW)) u_step (
      .op   (op_r),
      .fill (fill_r),
      .en   (rem > AW'(i)),
      .d    (stage[i]),
      .y    (stage[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && !imm) state_nxt = S_RUN;
      S_RUN:   if (flush || last_step) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      rem    <= '0;
      op_r   <= OP_NOP;
      fill_r <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_r   <= cmd_op_e;
        fill_r <= cmd_fill;
        rem    <= eff_amt;
        done   <= imm;
        if (cmd_op_e == OP_LOAD)     q <= data;
        else if (cmd_op_e == OP_CLR) q <= '0;
      end else if (state == S_RUN) begin
        if (flush) begin
          rem <= '0;
        end else begin
          q    <= stage[STEP];
          rem  <= rem - step_k;
          done <= last_step;
        end
      end
    end
  end

  assign busy      = (state == S_RUN);
  assign cmd_ready = (state == S_IDLE);
endmodule
